posit_stream_checker: RTL and testbench
=======================================

Name: posit_stream_checker

Overview:
- Streaming self-check block for pipelined posit arithmetic units (multiplier, adder) in the Pair-HMM datapath.
- Captures the expected result of each issued operation in an in-order FIFO and pops it when the unit under check signals completion.
- Compares the two posit codes and keeps error statistics, so that latency-agnostic on-chip and bench checking needs no fixed-offset indexing.
- Supports any posit width, FIFO depth, tolerance and completion timeout.

Parameters:
- N, 8, posit width in bits (4..32).
- DEPTH, 16, expected-value FIFO depth; power of two, 2..256.
- TOL, 0, maximum accepted absolute code difference (unsigned, N bits).
- TIMEOUT, 64, cycles without a completion while the FIFO is non-empty before a timeout is flagged; 0 disables the check.

Ports:
- aclk in 1: clock; all logic samples on the rising edge.
- aresetn in 1: synchronous active-low reset.
- issue in 1: one operation issued this cycle.
- issue_expected in N: expected posit result of the issued operation.
- done in 1: unit under check presents a result this cycle.
- result in N: posit result from the unit under check.
- clear in 1: synchronous clear of the statistics only; the FIFO is not affected.
- chk_valid out 1: one-cycle pulse; a comparison was completed.
- chk_diff out N: absolute difference of the last comparison.
- chk_fail out 1: high with chk_valid when that comparison failed.
- sample_count out 32: comparisons performed.
- fail_count out 32: failed comparisons.
- max_diff out N: largest chk_diff seen.
- first_fail_idx out 32: sample_count value of the first failure; all-ones if none.
- overflow out 1: sticky; issue arrived while the FIFO was full.
- underflow out 1: sticky; done arrived while the FIFO was empty.
- timeout out 1: sticky; completion timeout expired.
- pending out log2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (aresetn=0 at a rising edge) has priority over everything, including an in-flight operation.
  - FIFO emptied; pending=0.
  - All counters, max_diff, chk_diff and sticky flags set to 0.
  - chk_valid=0, chk_fail=0.
  - first_fail_idx set to all-ones.
- FIFO:
  - issue=1 and not full: push issue_expected.
  - issue=1 and full: value dropped; overflow set.
  - done=1 and not empty: pop the head and compare it against result.
  - done=1 and empty: no comparison; underflow set; chk_valid stays 0.
  - Simultaneous issue and done when empty: the push completes and the done is treated as underflow. Same-cycle bypass is not allowed.
  - Simultaneous issue and done when full: the pop frees a slot, so the push is accepted with no overflow.
  - pending changes by +1, -1 or 0 accordingly.
- Comparison, 1-cycle latency: chk_valid, chk_diff, chk_fail and the statistics update on the edge after the done cycle.
  - Codes are interpreted as N-bit two's-complement integers (posit order is monotonic in this view).
  - NaR is 1 followed by N-1 zeros.
  - Both NaR: diff=0.
  - Exactly one NaR: diff = all-ones, always a failure.
  - Otherwise diff = |expected - result|, computed in N+1 bits and saturated to all-ones.
  - Fail when diff > TOL.
- Statistics:
  - sample_count increments per comparison.
  - fail_count increments per failure.
  - max_diff = max(max_diff, diff).
  - first_fail_idx latches the pre-increment sample_count on the first failure only.
  - Counters saturate at 2^32-1.
  - clear=1 resets sample_count, fail_count, max_diff and first_fail_idx.
  - clear does not reset the sticky flags or the FIFO.
  - clear coincident with a comparison: clear wins; that comparison is not counted, but chk_valid still pulses.
- Timeout:
  - A cycle counter runs while pending>0 and done=0.
  - It resets on done or when pending=0.
  - When it reaches TIMEOUT, timeout is set (sticky) and the counter holds.

Test Plan:
- N=8, TOL=0: issue 0x40 and 0x20, then done with results 0x40 and 0x21 three cycles later.
  - Comparison 1: chk_valid pulse, diff=0, no fail.
  - Comparison 2: diff=1, chk_fail=1.
  - Final state: fail_count=1, first_fail_idx=1, max_diff=1.
- Signed/NaR handling: expected 0x7F vs result 0x81 → diff=0xFE, fail. Expected 0x80 vs result 0x80 → diff=0, pass. Expected 0x80 vs result 0x00 → diff=0xFF, fail.
- DEPTH=4: five back-to-back issues with no done → pending=4, overflow=1. Then four dones → four comparisons in issue order and pending=0. A fifth done → underflow=1 and no chk_valid.
- Full FIFO with issue and done in the same cycle → pending stays 4, overflow stays 0. Empty FIFO with issue and done in the same cycle → underflow=1, pending=1.
- TIMEOUT=10: one issue, no done → timeout rises exactly 10 cycles after the issue. Then aresetn low for one cycle mid-operation → all outputs at reset values, first_fail_idx all-ones.
- TOL=2: diffs 2 then 3 → first passes, second fails. Then clear coincident with a further comparison → sample_count=0, chk_valid pulses, sticky flags unchanged.

Source files
------------

// File: rtl/posit_stream_checker.sv
// posit_stream_checker
//
// Purpose: self-check block for pipelined posit units. The expected result of
// every issued operation is held in an in-order FIFO. When the unit under check
// signals completion, the head is popped and compared against the produced
// code. The block keeps running error statistics, so checking does not depend
// on knowing the unit's latency.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   issue/issue_expected push an expected posit code
//   done/result          unit under check presents a result (pops the head)
//   clear                synchronous clear of the statistics only
//   chk_valid/diff/fail  per-comparison pulse, |exp-res| and failure flag
//   sample_count         comparisons performed (saturating)
//   fail_count           failed comparisons (saturating)
//   max_diff             largest diff seen
//   first_fail_idx       sample_count at the first failure, all-ones if none
//   overflow/underflow   sticky FIFO misuse flags
//   timeout              sticky completion-timeout flag
//   pending              FIFO occupancy
module posit_stream_checker #(
    parameter int N       = 8,
    parameter int DEPTH   = 16,
    parameter int TOL     = 0,
    parameter int TIMEOUT = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     issue,
    input  logic [N-1:0]             issue_expected,
    input  logic                     done,
    input  logic [N-1:0]             result,
    input  logic                     clear,
    output logic                     chk_valid,
    output logic [N-1:0]             chk_diff,
    output logic                     chk_fail,
    output logic [31:0]              sample_count,
    output logic [31:0]              fail_count,
    output logic [N-1:0]             max_diff,
    output logic [31:0]              first_fail_idx,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int            AW    = $clog2(DEPTH);
    localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [N-1:0]  NAR   = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  TOL_V = N'(TOL);
    localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT);
    localparam bit            TO_EN = (TIMEOUT != 0);

    // |a - b| of two's-complement codes in N+1 bits, saturated to N bits.
    function automatic logic [N-1:0] sat_abs_diff(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        logic signed [N:0] d;
        logic [N:0]        mag;
        d   = N'(a) - N'(b);
        d   = $signed({a[N-1], a}) - $signed({b[N-1], b});
        mag = d[N] ? $unsigned(-d) : $unsigned(d);
        return mag[N] ? {N{1'b1}} : mag[N-1:0];
    endfunction

    // NaR is unordered: both NaR compare equal, a single NaR is maximally off.
    function automatic logic [N-1:0] posit_diff(input logic [N-1:0] e,
                                                input logic [N-1:0] r);
        if (e == NAR && r == NAR)
            return '0;
        else if (e == NAR || r == NAR)
            return {N{1'b1}};
        else
            return sat_abs_diff($signed(e), $signed(r));
    endfunction

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tcnt, tcnt_next;

    logic                full, empty, pop, push;
    logic signed [N-1:0] head_p0;
    logic [N-1:0]        diff_p0;
    logic                one_nar_p0, fail_p0;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = done && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push    = issue && (!full || pop);
    assign pending = count;

    // Stage p0: compare the FIFO head against the incoming result.
    assign head_p0    = $signed(mem[rd_ptr]);
    assign diff_p0    = posit_diff(mem[rd_ptr], result);
    assign one_nar_p0 = (mem[rd_ptr] == NAR) != (result == NAR);
    assign fail_p0    = one_nar_p0 || (diff_p0 > TOL_V);

    always_comb begin
        tcnt_next = tcnt;
        if (empty || done)
            tcnt_next = '0;
        else if (tcnt != TO_V)
            tcnt_next = tcnt + TW'(1);
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= issue_expected;
    end

    // Stage p1: registered comparison outputs, statistics and flags.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tcnt           <= '0;
            chk_valid      <= 1'b0;
            chk_fail       <= 1'b0;
            chk_diff       <= '0;
            sample_count   <= '0;
            fail_count     <= '0;
            max_diff       <= '0;
            first_fail_idx <= '1;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (issue && !push)
                overflow <= 1'b1;
            if (done && empty)
                underflow <= 1'b1;

            tcnt <= tcnt_next;
            if (TO_EN && tcnt_next == TO_V)
                timeout <= 1'b1;

            chk_valid <= pop;
            chk_fail  <= pop && fail_p0;
            if (pop)
                chk_diff <= diff_p0;

            if (clear) begin
                sample_count   <= '0;
                fail_count     <= '0;
                max_diff       <= '0;
                first_fail_idx <= '1;
            end else if (pop) begin
                if (sample_count != '1)
                    sample_count <= sample_count + 32'd1;
                if (fail_p0) begin
                    if (fail_count == '0)
                        first_fail_idx <= sample_count;
                    if (fail_count != '1)
                        fail_count <= fail_count + 32'd1;
                end
                if (diff_p0 > max_diff)
                    max_diff <= diff_p0;
            end
        end
    end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Testbench for posit_stream_checker: two instances (TOL=0 and TOL=2) share the
// stimulus; a queue-based reference model predicts every output each cycle.
module tb_posit_stream_checker;

    localparam int N       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic       aclk = 1'b0;
    logic       aresetn, issue, done, clear;
    logic [7:0] issue_expected, result;

    logic       cv  [2];
    logic [7:0] cd  [2];
    logic       cf  [2];
    logic [31:0] sc [2];
    logic [31:0] fc [2];
    logic [7:0] md  [2];
    logic [31:0] ffi[2];
    logic       ov  [2];
    logic       un  [2];
    logic       to  [2];
    logic [2:0] pend[2];

    always #5 aclk = ~aclk;

    posit_stream_checker #(.N(N), .DEPTH(DEPTH), .TOL(0), .TIMEOUT(TIMEOUT)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .issue(issue), .issue_expected(issue_expected),
        .done(done), .result(result), .clear(clear),
        .chk_valid(cv[0]), .chk_diff(cd[0]), .chk_fail(cf[0]),
        .sample_count(sc[0]), .fail_count(fc[0]), .max_diff(md[0]),
        .first_fail_idx(ffi[0]), .overflow(ov[0]), .underflow(un[0]),
        .timeout(to[0]), .pending(pend[0]));

    posit_stream_checker #(.N(N), .DEPTH(DEPTH), .TOL(2), .TIMEOUT(TIMEOUT)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .issue(issue), .issue_expected(issue_expected),
        .done(done), .result(result), .clear(clear),
        .chk_valid(cv[1]), .chk_diff(cd[1]), .chk_fail(cf[1]),
        .sample_count(sc[1]), .fail_count(fc[1]), .max_diff(md[1]),
        .first_fail_idx(ffi[1]), .overflow(ov[1]), .underflow(un[1]),
        .timeout(to[1]), .pending(pend[1]));

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          q[$];
    int          m_tc;
    bit          m_to, m_ov, m_un, m_cv;
    int          m_cd;
    bit          m_cf [2];
    int          m_sc [2];
    int          m_fc [2];
    int          m_md [2];
    logic [31:0] m_ffi[2];

    function automatic int tol_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // Codes as signed 8-bit integers; NaR (128) handled separately.
    function automatic int mdiff(input int e, input int r);
        int es, rs, d;
        if (e == 128 && r == 128) return 0;
        if (e == 128 || r == 128) return 255;
        es = (e >= 128) ? e - 256 : e;
        rs = (r >= 128) ? r - 256 : r;
        d  = es - rs;
        if (d < 0) d = -d;
        if (d > 255) d = 255;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tc = 0; m_to = 0; m_ov = 0; m_un = 0; m_cv = 0; m_cd = 0;
        for (int k = 0; k < 2; k++) begin
            m_cf[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_md[k] = 0; m_ffi[k] = '1;
        end
    endtask

    task automatic model_step(input bit iss, input int e, input bit dn, input int r, input bit clr);
        int  pre, h, d;
        bit  pop, nar1;
        pre = q.size();
        pop = dn && (pre > 0);
        d   = 0;
        m_cv = 0;
        for (int k = 0; k < 2; k++) m_cf[k] = 0;
        if (dn && pre == 0) m_un = 1;
        if (pop) begin
            h    = q.pop_front();
            d    = mdiff(h, r);
            nar1 = (h == 128) != (r == 128);
            m_cv = 1;
            m_cd = d;
            for (int k = 0; k < 2; k++) m_cf[k] = nar1 || (d > tol_of(k));
        end
        if (iss) begin
            if (q.size() < DEPTH) q.push_back(e & 255);
            else m_ov = 1;
        end
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_sc[k] = 0; m_fc[k] = 0; m_md[k] = 0; m_ffi[k] = '1;
            end else if (pop) begin
                if (m_cf[k] && m_fc[k] == 0) m_ffi[k] = 32'(m_sc[k]);
                m_sc[k]++;
                if (m_cf[k]) m_fc[k]++;
                if (d > m_md[k]) m_md[k] = d;
            end
        end
        if (pre == 0 || dn) m_tc = 0;
        else if (m_tc < TIMEOUT) m_tc++;
        if (m_tc == TIMEOUT) m_to = 1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("chk_valid%0d", k),      32'(cv[k]),   32'(m_cv));
            chk($sformatf("chk_diff%0d", k),       32'(cd[k]),   32'(m_cd));
            chk($sformatf("chk_fail%0d", k),       32'(cf[k]),   32'(m_cf[k]));
            chk($sformatf("sample_count%0d", k),   sc[k],        32'(m_sc[k]));
            chk($sformatf("fail_count%0d", k),     fc[k],        32'(m_fc[k]));
            chk($sformatf("max_diff%0d", k),       32'(md[k]),   32'(m_md[k]));
            chk($sformatf("first_fail_idx%0d", k), ffi[k],       m_ffi[k]);
            chk($sformatf("overflow%0d", k),       32'(ov[k]),   32'(m_ov));
            chk($sformatf("underflow%0d", k),      32'(un[k]),   32'(m_un));
            chk($sformatf("timeout%0d", k),        32'(to[k]),   32'(m_to));
            chk($sformatf("pending%0d", k),        32'(pend[k]), 32'(q.size()));
        end
    endtask

    task automatic tick(input bit iss, input int e, input bit dn, input int r, input bit clr);
        issue = iss; issue_expected = 8'(e); done = dn; result = 8'(r); clear = clr;
        @(posedge aclk);
        model_step(iss, e, dn, r, clr);
        #1;
        check_all();
        issue = 0; done = 0; clear = 0;
    endtask

    // Reset asserted while inputs are active: reset must win.
    task automatic do_reset();
        aresetn = 0; issue = 1; done = 1; clear = 0;
        issue_expected = 8'h55; result = 8'h11;
        @(posedge aclk);
        model_reset();
        #1;
        check_all();
        aresetn = 1; issue = 0; done = 0;
    endtask

    initial begin
        int e, r, h;
        aresetn = 1; issue = 0; done = 0; clear = 0;
        issue_expected = 0; result = 0;
        model_reset();
        #2;
        do_reset();
        do_reset();
        chk("rst_ffi", ffi[0], 32'hFFFF_FFFF);

        // Basic in-order comparison
        tick(1, 8'h40, 0, 0, 0);
        tick(1, 8'h20, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 8'h40, 0);
        chk("t1_valid1", 32'(cv[0]), 1);
        chk("t1_diff1",  32'(cd[0]), 0);
        tick(0, 0, 1, 8'h21, 0);
        chk("t1_diff2",  32'(cd[0]), 1);
        chk("t1_fail2",  32'(cf[0]), 1);
        tick(0, 0, 0, 0, 0);
        chk("t1_failcnt", fc[0], 1);
        chk("t1_ffi",     ffi[0], 1);
        chk("t1_maxdiff", 32'(md[0]), 1);
        chk("t1_valid_off", 32'(cv[0]), 0);

        // Signed ordering and NaR
        tick(1, 8'h7F, 0, 0, 0);
        tick(1, 8'h80, 0, 0, 0);
        tick(1, 8'h80, 0, 0, 0);
        tick(0, 0, 1, 8'h81, 0);
        chk("nar_diff_fe", 32'(cd[0]), 32'hFE);
        chk("nar_fail_fe", 32'(cf[0]), 1);
        tick(0, 0, 1, 8'h80, 0);
        chk("nar_both", 32'(cd[1]), 0);
        chk("nar_both_pass", 32'(cf[0]), 0);
        tick(0, 0, 1, 8'h00, 0);
        chk("nar_one", 32'(cd[1]), 32'hFF);
        chk("nar_one_fail", 32'(cf[1]), 1);

        // Overflow, in-order drain, underflow
        do_reset();
        for (int i = 1; i <= 5; i++) tick(1, i, 0, 0, 0);
        chk("ovf_pending", 32'(pend[0]), 4);
        chk("ovf_flag", 32'(ov[0]), 1);
        for (int i = 1; i <= 4; i++) tick(0, 0, 1, i, 0);
        chk("drain_pending", 32'(pend[0]), 0);
        chk("drain_fails", fc[0], 0);
        tick(0, 0, 1, 3, 0);
        chk("udf_flag", 32'(un[0]), 1);
        chk("udf_novalid", 32'(cv[0]), 0);

        // Simultaneous issue/done at full and at empty
        do_reset();
        for (int i = 1; i <= 4; i++) tick(1, i, 0, 0, 0);
        tick(1, 9, 1, 1, 0);
        chk("full_both_pending", 32'(pend[0]), 4);
        chk("full_both_ovf", 32'(ov[0]), 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 2, 0);
        tick(1, 7, 1, 0, 0);
        chk("empty_both_udf", 32'(un[0]), 1);
        chk("empty_both_pending", 32'(pend[0]), 1);
        chk("empty_both_novalid", 32'(cv[0]), 0);

        // Timeout exactly TIMEOUT cycles after the issue, then reset mid-op
        do_reset();
        tick(1, 8'h33, 0, 0, 0);
        for (int i = 1; i < TIMEOUT; i++) tick(0, 0, 0, 0, 0);
        chk("to_before", 32'(to[0]), 0);
        tick(0, 0, 0, 0, 0);
        chk("to_at", 32'(to[0]), 1);
        tick(1, 8'h44, 0, 0, 0);
        do_reset();
        chk("rst_mid_pending", 32'(pend[0]), 0);
        chk("rst_mid_to", 32'(to[0]), 0);
        chk("rst_mid_ffi", ffi[1], 32'hFFFF_FFFF);
        chk("rst_mid_sc", sc[0], 0);

        // Tolerance and clear coincident with a comparison
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 8'h10, 0, 0, 0);
        tick(0, 0, 1, 8'h12, 0);
        chk("tol_pass", 32'(cf[1]), 0);
        chk("tol_diff2", 32'(cd[1]), 2);
        tick(0, 0, 1, 8'h13, 0);
        chk("tol_fail", 32'(cf[1]), 1);
        chk("tol_sc", sc[1], 2);
        tick(0, 0, 1, 8'h10, 1);
        chk("clr_sc", sc[1], 0);
        chk("clr_valid", 32'(cv[1]), 1);
        chk("clr_udf_kept", 32'(un[1]), 1);

        // Randomized traffic with an occasional reset
        for (int c = 0; c < 600; c++) begin
            if (c % 200 == 199) begin
                do_reset();
            end else begin
                e = ($urandom_range(0, 7) == 0) ? 128 : int'($urandom_range(0, 255));
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    h = q[0];
                    r = (h + int'($urandom_range(0, 6)) - 3) & 255;
                end else begin
                    r = ($urandom_range(0, 5) == 0) ? 128 : int'($urandom_range(0, 255));
                end
                tick(bit'($urandom_range(0, 1)), e, bit'($urandom_range(0, 2) != 0), r,
                     bit'($urandom_range(0, 40) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
